pwm_multi_ctrl: RTL and testbench

PWM_MULTI_CTRL -- requirements
Module: pwm_multi_ctrl

---
 rtl/pwm_multi_ctrl_pkg.sv | 26 ++
 rtl/pwm_multi_ctrl_channel.sv | 44 ++++
 rtl/pwm_multi_ctrl.sv | 89 ++++++++
 tb/tb_pwm_multi_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_multi_ctrl_pkg.sv
// Shared register map, minimum period and address decode for the multi-channel PWM block.
package pwm_multi_ctrl_pkg;

  localparam int unsigned ADDR_PERIOD    = 0;
  localparam int unsigned ADDR_ENABLE    = 1;
  localparam int unsigned ADDR_DUTY_BASE = 2;
  localparam int unsigned MIN_PERIOD     = 2;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_PERIOD,
    REG_ENABLE,
    REG_DUTY
  } reg_sel_e;

  // Addresses beyond the last duty register select nothing, so such writes are dropped.
  function automatic reg_sel_e decode_addr(input int unsigned addr, input int unsigned ch_num);
    reg_sel_e sel;
    if (addr == ADDR_PERIOD) sel = REG_PERIOD;
    else if (addr == ADDR_ENABLE) sel = REG_ENABLE;
    else if (addr < ADDR_DUTY_BASE + ch_num) sel = REG_DUTY;
    else sel = REG_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/pwm_multi_ctrl_channel.sv
// One PWM channel: pending/active duty and enable, plus the registered output compare.
module pwm_channel
  import pwm_multi_ctrl_pkg::*;
#(
  parameter int CNT_W    = 28,
  parameter int DEF_DUTY = 25000000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [CNT_W-1:0] cnt,
  input  logic             wrap,
  input  logic             duty_wr,
  input  logic [CNT_W-1:0] duty_data,
  input  logic             enable_wr,
  input  logic             enable_data,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_pend;
  logic [CNT_W-1:0] duty_act;
  logic             enable_pend;
  logic             enable_act;

  // Active copies are refreshed from the pre-write pending values, so a write landing
  // on the wrap cycle only takes effect one period later.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      duty_pend   <= CNT_W'(DEF_DUTY);
      duty_act    <= CNT_W'(DEF_DUTY);
      enable_pend <= 1'b1;
      enable_act  <= 1'b1;
      pwm         <= 1'b0;
    end else begin
      if (wrap) begin
        duty_act   <= duty_pend;
        enable_act <= enable_pend;
      end
      if (duty_wr) duty_pend <= duty_data;
      if (enable_wr) enable_pend <= enable_data;
      pwm <= enable_act && (cnt < duty_act);
    end
  end

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM controller: shared period counter, double-buffered register file,
// one pwm_channel per output.
module pwm_multi_ctrl
  import pwm_multi_ctrl_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int CNT_W      = 28,
  parameter int ADDR_W     = 5,
  parameter int DEF_PERIOD = 50000000,
  parameter int DEF_DUTY   = 25000000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [CNT_W-1:0]  WR_DATA,
  output logic [CH_NUM-1:0] PWM_OUT,
  output logic              PERIOD_STB
);

  logic              rst_n_sync;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period_pend;
  logic [CNT_W-1:0]  period_act;
  logic [CNT_W-1:0]  period_eff;
  logic              wrap;
  reg_sel_e          wr_sel;
  logic              wr_period;
  logic              wr_enable;
  logic [CH_NUM-1:0] wr_duty;

  // Reset asserts immediately but releases on a clock edge, so every register leaves
  // reset together one cycle after RST_N rises.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_n_sync <= 1'b0;
    else        rst_n_sync <= 1'b1;
  end

  always_comb begin
    wr_sel    = decode_addr(32'(WR_ADDR), CH_NUM);
    wr_period = WR_EN && (wr_sel == REG_PERIOD);
    wr_enable = WR_EN && (wr_sel == REG_ENABLE);
    for (int k = 0; k < CH_NUM; k++) begin
      wr_duty[k] = WR_EN && (wr_sel == REG_DUTY) && (32'(WR_ADDR) == ADDR_DUTY_BASE + k);
    end
  end

  // Periods of 0 or 1 are stretched to the minimum so the counter always has a wrap cycle.
  always_comb begin
    period_eff = (period_act < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_act;
    wrap       = (cnt >= period_eff - CNT_W'(1));
  end

  always_ff @(posedge CLK or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      cnt         <= '0;
      period_pend <= CNT_W'(DEF_PERIOD);
      period_act  <= CNT_W'(DEF_PERIOD);
      PERIOD_STB  <= 1'b0;
    end else begin
      if (wrap) begin
        cnt        <= '0;
        period_act <= period_pend;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (wr_period) period_pend <= WR_DATA;
      PERIOD_STB <= wrap;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    pwm_channel #(
      .CNT_W    (CNT_W),
      .DEF_DUTY (DEF_DUTY)
    ) u_ch (
      .CLK         (CLK),
      .RST_N       (rst_n_sync),
      .cnt         (cnt),
      .wrap        (wrap),
      .duty_wr     (wr_duty[k]),
      .duty_data   (WR_DATA),
      .enable_wr   (wr_enable),
      .enable_data (WR_DATA[k]),
      .pwm         (PWM_OUT[k])
    );
  end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed and randomized checks of pwm_multi_ctrl against a cycle-level model of the register rules.
module tb_pwm_multi_ctrl;

  localparam int CH_NUM = 4;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 5;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              WR_EN = 1'b0;
  logic [ADDR_W-1:0] WR_ADDR = '0;
  logic [CNT_W-1:0]  WR_DATA = '0;
  logic [CH_NUM-1:0] PWM_OUT;
  logic              PERIOD_STB;

  pwm_multi_ctrl #(
    .CH_NUM     (CH_NUM),
    .CNT_W      (CNT_W),
    .ADDR_W     (ADDR_W),
    .DEF_PERIOD (10),
    .DEF_DUTY   (5)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .PWM_OUT    (PWM_OUT),
    .PERIOD_STB (PERIOD_STB)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int hc[CH_NUM];

  // Reference state: settings as plain integers, counter as an integer.
  int         m_cnt, m_per_p, m_per_a, m_hold;
  int         m_duty_p[CH_NUM];
  int         m_duty_a[CH_NUM];
  logic [3:0] m_en_p, m_en_a, m_pwm;
  logic       m_stb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_per_p = 10; m_per_a = 10; m_hold = 0;
    for (int k = 0; k < CH_NUM; k++) begin
      m_duty_p[k] = 5; m_duty_a[k] = 5;
    end
    m_en_p = 4'hF; m_en_a = 4'hF; m_pwm = 4'h0; m_stb = 1'b0;
  endfunction

  function automatic void model_step(input bit we, input int addr, input int data);
    int  p;
    bit  wrap;
    p    = (m_per_a < 2) ? 2 : m_per_a;
    wrap = (m_cnt >= p - 1);
    for (int k = 0; k < CH_NUM; k++) m_pwm[k] = m_en_a[k] && (m_cnt < m_duty_a[k]);
    m_stb = wrap;
    if (wrap) begin
      m_cnt = 0; m_per_a = m_per_p; m_duty_a = m_duty_p; m_en_a = m_en_p;
    end else begin
      m_cnt = m_cnt + 1;
    end
    if (we) begin
      if (addr == 0) m_per_p = data;
      else if (addr == 1) m_en_p = data[3:0];
      else if (addr >= 2 && addr < 2 + CH_NUM) m_duty_p[addr - 2] = data;
    end
  endfunction

  task automatic tick();
    bit we;
    int a, d;
    we = WR_EN; a = int'(WR_ADDR); d = int'(WR_DATA);
    @(posedge CLK);
    if (!RST_N) model_reset();
    else if (m_hold > 0) m_hold--;
    else model_step(we, a, d);
    #1;
    chk("pwm_out", 32'(PWM_OUT), 32'(m_pwm));
    chk("period_stb", 32'(PERIOD_STB), 32'(m_stb));
    for (int k = 0; k < CH_NUM; k++) hc[k] += int'(PWM_OUT[k]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_counts();
    for (int k = 0; k < CH_NUM; k++) hc[k] = 0;
  endtask

  task automatic wr(input int addr, input int data);
    WR_EN = 1'b1; WR_ADDR = ADDR_W'(addr); WR_DATA = CNT_W'(data);
    tick();
    WR_EN = 1'b0;
  endtask

  // Cycles until the next strobe; a missing strobe returns 64, which no caller expects.
  task automatic wait_stb(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (PERIOD_STB !== 1'b1 && n < 64);
  endtask

  task automatic release_reset();
    RST_N = 1'b1;
    m_hold = 1;
  endtask

  // Default 5-high/5-low pattern from release; edge 1 is absorbed by the reset synchroniser.
  task automatic check_default_pattern();
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("dflt_pwm", 32'(PWM_OUT), (i >= 2 && ((i - 2) % 10) < 5) ? 32'hF : 32'h0);
      chk("dflt_stb", 32'(PERIOD_STB), (i >= 11 && ((i - 11) % 10) == 0) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    clr_counts();

    // Reset state and release
    ticks(3);
    chk("reset_pwm", 32'(PWM_OUT), 32'h0);
    chk("reset_stb", 32'(PERIOD_STB), 32'h0);
    release_reset();
    check_default_pattern();

    // Mid-period duty write at CNT = 4
    clr_counts();
    ticks(4);
    wr(3, 3);
    ticks(5);
    chk("midwr_cur_ch1", 32'(hc[1]), 32'd5);
    chk("midwr_cur_ch0", 32'(hc[0]), 32'd5);
    clr_counts();
    ticks(10);
    chk("midwr_next_ch1", 32'(hc[1]), 32'd3);
    chk("midwr_next_ch0", 32'(hc[0]), 32'd5);
    chk("midwr_next_ch2", 32'(hc[2]), 32'd5);
    chk("midwr_next_ch3", 32'(hc[3]), 32'd5);

    // Period write exactly on the wrap cycle
    ticks(9);
    wr(0, 6);
    chk("collision_wrap", 32'(PERIOD_STB), 32'h1);
    wait_stb(n); chk("collision_p1", 32'(n), 32'd10);
    wait_stb(n); chk("collision_p2", 32'(n), 32'd6);
    wait_stb(n); chk("collision_p3", 32'(n), 32'd6);

    // Duty boundaries at P = 6
    wr(4, 0);
    wr(5, 200);
    wait_stb(n); wait_stb(n);
    clr_counts();
    ticks(6);
    chk("duty0_low", 32'(hc[2]), 32'd0);
    chk("duty_big_high", 32'(hc[3]), 32'd6);
    chk("duty5_of6", 32'(hc[0]), 32'd5);

    // Period clamping
    wr(0, 0);
    wait_stb(n); wait_stb(n);
    wait_stb(n); chk("period0_len", 32'(n), 32'd2);
    clr_counts();
    ticks(2);
    chk("period0_big_high", 32'(hc[3]), 32'd2);
    chk("period0_duty0_low", 32'(hc[2]), 32'd0);
    wr(0, 1);
    wait_stb(n); wait_stb(n);
    wait_stb(n); chk("period1_len", 32'(n), 32'd2);

    // Enable mask and an unmapped address
    wr(0, 10);
    wr(4, 5);
    wr(5, 5);
    wr(1, 5);
    wr(9, 0);
    wait_stb(n); wait_stb(n);
    clr_counts();
    ticks(10);
    chk("en_ch0", 32'(hc[0]), 32'd5);
    chk("en_ch1", 32'(hc[1]), 32'd0);
    chk("en_ch2", 32'(hc[2]), 32'd5);
    chk("en_ch3", 32'(hc[3]), 32'd0);
    wait_stb(n); chk("addr9_period", 32'(n), 32'd10);

    // Randomized writes against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int a;
        a = int'($urandom_range(0, 9));
        if (a == 0) wr(a, int'($urandom_range(0, 14)));
        else if (a == 1) wr(a, int'($urandom_range(0, 255)));
        else wr(a, int'($urandom_range(0, 20)));
      end else begin
        tick();
      end
    end

    // Reset mid-period with a pending duty write
    RST_N = 1'b0;
    #1;
    model_reset();
    ticks(3);
    release_reset();
    ticks(3);
    wr(2, 2);
    tick();
    RST_N = 1'b0;
    #1;
    chk("async_rst_pwm", 32'(PWM_OUT), 32'h0);
    chk("async_rst_stb", 32'(PERIOD_STB), 32'h0);
    model_reset();
    ticks(2);
    release_reset();
    check_default_pattern();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
